// File: rtl/alu_logic_seq_if.sv
// alu_logic_seq_if: request/response bundle for the sliced logic unit.
// flags exist only when ALU_LOGIC_FLAGS_EN is defined.
interface alu_logic_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;
`ifdef ALU_LOGIC_FLAGS_EN
  logic [1:0]         flags;

  modport master (
    output start, op, a, b,
    input  busy, done, res, flags
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, res, flags
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, res
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, res
  );
`endif
endinterface

// File: rtl/alu_logic_seq.sv
// alu_logic_seq: 8-op bitwise unit, SLICE bits per cycle, start/busy/done.
// Optional ALU_LOGIC_FLAGS_EN adds zero/parity flags on the result.
module alu_logic_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu_logic_seq_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("alu_logic_seq: WIDTH must be >= 2");
  end
  if (WIDTH % SLICE != 0) begin : g_chk_slice
    $error("alu_logic_seq: SLICE must divide WIDTH");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic [SLICE-1:0] slice_r;
`ifdef ALU_LOGIC_FLAGS_EN
  logic [1:0]       flags_q, flags_d;
`endif

  function automatic logic [SLICE-1:0] f_slice(
    input logic [2:0]       op,
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y
  );
    logic [SLICE-1:0] r;
    r = '0;
    unique case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x ^ y;
      3'b011: r = ~(x & y);
      3'b100: r = ~(x | y);
      3'b101: r = ~(x ^ y);
      3'b110: r = ~x;
      3'b111: r = y;
    endcase
    return r;
  endfunction

  assign slice_r = f_slice(
    op_q,
    a_q[idx_q*SLICE +: SLICE],
    b_q[idx_q*SLICE +: SLICE]
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    done_d  = 1'b0;
`ifdef ALU_LOGIC_FLAGS_EN
    flags_d = flags_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          acc_d   = '0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d[idx_q*SLICE +: SLICE] = slice_r;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          // Last slice: publish the completed word this edge.
          res_d   = acc_d;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
`ifdef ALU_LOGIC_FLAGS_EN
          flags_d = {^acc_d, ~|acc_d};
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
`ifdef ALU_LOGIC_FLAGS_EN
      flags_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      done_q  <= done_d;
`ifdef ALU_LOGIC_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = done_q;
  assign bus.res  = {{WIDTH{1'b0}}, res_q};
`ifdef ALU_LOGIC_FLAGS_EN
  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_logic_seq.sv
// tb_alu_logic_seq: directed checks for alu_logic_seq (WIDTH=8, SLICE=2).
// Flag checks run only when ALU_LOGIC_FLAGS_EN is defined.
module tb_alu_logic_seq;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_logic_seq_if #(.WIDTH(8)) bus ();

  alu_logic_seq #(
    .WIDTH(8),
    .SLICE(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(
    input  logic [7:0]  ta,
    input  logic [7:0]  tb_v,
    input  logic [2:0]  top,
    output int          bcnt,
    output logic [15:0] r,
    output bit          ok
  );
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.op    = top;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bcnt = 0;
    ok   = 1'b0;
    r    = 'x;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        r  = bus.res;
      end else begin
        if (bus.busy) bcnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_done: got %b want 0", bus.done);
    end
    n_cmp++;
    if (bus.res !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_res: got %h want 0000", bus.res);
    end
    rst = 1'b0;
  endtask

  task automatic test_and();
    int          bc;
    logic [15:0] r;
    bit          ok;
    run_op(8'hF0, 8'h3C, 3'b000, bc, r, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL and_done: got %b want 1", ok);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_bad++;
      $display("FAIL and_busy_cycles: got %0d want 4", bc);
    end
    n_cmp++;
    if (r !== 16'h0030) begin
      n_bad++;
      $display("FAIL and_res: got %h want 0030", r);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL and_done_pulse: got %b want 0", bus.done);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.res !== 16'h0030) begin
      n_bad++;
      $display("FAIL and_res_hold: got %h want 0030", bus.res);
    end
  endtask

  task automatic test_op_sweep();
    logic [15:0] exp_t [8];
    int          bc;
    logic [15:0] r;
    bit          ok;
    exp_t = '{16'h0030, 16'h00FC, 16'h00CC, 16'h00CF,
              16'h0003, 16'h0033, 16'h000F, 16'h003C};
    for (int k = 0; k < 8; k++) begin
      run_op(8'hF0, 8'h3C, 3'(k), bc, r, ok);
      n_cmp++;
      if (!ok || r !== exp_t[k]) begin
        n_bad++;
        $display("FAIL sweep_op%0d: got %h (done=%b) want %h",
                 k, r, ok, exp_t[k]);
      end
    end
  endtask

  task automatic test_isolation();
    int          ndone;
    bit          restart;
    logic [15:0] rcap;
    @(negedge clk);
    bus.a     = 8'hAA;
    bus.b     = 8'hFF;
    bus.op    = 3'b000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a     = 8'h00;
    bus.op    = 3'b001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone   = 0;
    restart = 1'b0;
    rcap    = 'x;
    for (int i = 0; i < 15; i++) begin
      if (ndone > 0 && bus.busy) restart = 1'b1;
      if (bus.done) begin
        ndone++;
        rcap = bus.res;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_bad++;
      $display("FAIL iso_done_count: got %0d want 1", ndone);
    end
    n_cmp++;
    if (rcap !== 16'h00AA) begin
      n_bad++;
      $display("FAIL iso_res: got %h want 00AA", rcap);
    end
    n_cmp++;
    if (restart !== 1'b0) begin
      n_bad++;
      $display("FAIL iso_no_restart: got %b want 0", restart);
    end
  endtask

  task automatic test_back_to_back();
    int dpos [$];
    int nlow;
    bit bad_res;
    @(negedge clk);
    bus.a     = 8'h0F;
    bus.b     = 8'h0F;
    bus.op    = 3'b010;
    bus.start = 1'b1;
    nlow    = 0;
    bad_res = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (!bus.busy) nlow++;
      if (bus.done) begin
        dpos.push_back(k);
        if (bus.res !== 16'h0000) bad_res = 1'b1;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (dpos.size() !== 3) begin
      n_bad++;
      $display("FAIL b2b_done_count: got %0d want 3", dpos.size());
    end
    for (int j = 1; j < dpos.size(); j++) begin
      n_cmp++;
      if (dpos[j] - dpos[j-1] !== 5) begin
        n_bad++;
        $display("FAIL b2b_period%0d: got %0d want 5",
                 j, dpos[j] - dpos[j-1]);
      end
    end
    n_cmp++;
    if (bad_res !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_res: got nonzero want 0000");
    end
    n_cmp++;
    if (nlow !== 3) begin
      n_bad++;
      $display("FAIL b2b_busy_low: got %0d want 3", nlow);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int          bc;
    logic [15:0] r;
    bit          ok;
    bit          seen;
    run_op(8'hAA, 8'h55, 3'b001, bc, r, ok);
    n_cmp++;
    if (!ok || r !== 16'h00FF) begin
      n_bad++;
      $display("FAIL rmid_pre: got %h want 00FF", r);
    end
    @(negedge clk);
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.op    = 3'b001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.res !== 16'h0000) begin
      n_bad++;
      $display("FAIL rmid_res: got %h want 0000", bus.res);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_no_done: got %b want 0", seen);
    end
    run_op(8'h12, 8'h34, 3'b001, bc, r, ok);
    n_cmp++;
    if (!ok || r !== 16'h0036) begin
      n_bad++;
      $display("FAIL rmid_after: got %h want 0036", r);
    end
  endtask

  task automatic test_rst_start();
    bit seen;
    @(negedge clk);
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.op    = 3'b000;
    bus.start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_busy: got %b want 0", bus.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_dropped: got activity=%b want 0", seen);
    end
    n_cmp++;
    if (bus.res !== 16'h0000) begin
      n_bad++;
      $display("FAIL rs_res: got %h want 0000", bus.res);
    end
  endtask

`ifdef ALU_LOGIC_FLAGS_EN
  task automatic test_flags();
    int          bc;
    logic [15:0] r;
    bit          ok;
    n_cmp++;
    if (bus.flags !== 2'b00) begin
      n_bad++;
      $display("FAIL flags_rst: got %b want 00", bus.flags);
    end
    run_op(8'h0F, 8'hF0, 3'b000, bc, r, ok);
    n_cmp++;
    if (!ok || r !== 16'h0000 || bus.flags !== 2'b01) begin
      n_bad++;
      $display("FAIL flags_zero: got %h/%b want 0000/01", r, bus.flags);
    end
    run_op(8'h07, 8'h00, 3'b001, bc, r, ok);
    n_cmp++;
    if (!ok || r !== 16'h0007 || bus.flags !== 2'b10) begin
      n_bad++;
      $display("FAIL flags_par: got %h/%b want 0007/10", r, bus.flags);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
`ifdef ALU_LOGIC_FLAGS_EN
    test_flags();
`endif
    test_and();
    test_op_sweep();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    test_rst_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_logic_seq.md
Name: alu_logic_seq

Overview:
- Parametrised, multi-operation successor to the team's single-function 8-bit AND unit.
- Applies one of eight bitwise operations to two WIDTH-bit operands, processing SLICE bits per clock under a start/busy/done handshake.
- Registers a zero-extended 2*WIDTH result, matching the double-width result bus the ALU result mux expects.
- Sits in the logical-ops group beside the arithmetic units; drives the shared result mux.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- SLICE, 2, bits processed per busy cycle; must divide WIDTH exactly.
- Elaboration fails (generate-time error) if WIDTH % SLICE != 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE
- op  input  3  operation select; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when res is updated
- res  output  2*WIDTH  result; upper WIDTH bits always 0

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND
  - 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 PASS b (a ignored)
- Reset, on any clk edge with rst=1, overriding everything:
  - state=IDLE; busy=0, done=0, res=0.
  - Internal slice counter and accumulator cleared.
  - An operation in progress is aborted: no done pulse, res not updated.
- IDLE:
  - On an edge with start=1: latch a, b, op; clear accumulator and slice index; enter BUSY; busy=1 from that edge.
  - start=0: remain in IDLE.
- BUSY:
  - Each edge computes bits [idx*SLICE +: SLICE] of the latched op into the accumulator and increments idx.
  - N = WIDTH/SLICE slice edges follow the start edge.
  - On the Nth slice edge: res <= {WIDTH'b0, final accumulator}; done=1; busy=0; return to IDLE.
- Latency: done is high in the cycle after the Nth edge following the accepting start edge. For defaults, N=4.
- done is high for exactly one cycle; res holds its value until the next completion or reset.
- Operands are isolated: a, b, op changes after the accepting edge have no effect on the result in flight.
- start while busy=1 is ignored and not queued.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). busy re-asserts on that edge, giving a one-cycle gap on busy between operations.
- Simultaneous rst and start: rst wins; start is dropped.
- No X propagation: every register is reset; op values never fall outside the encoding.

Optional Feature:
- Macro: ALU_LOGIC_FLAGS_EN
- Defined:
  - Adds output port flags, width 2.
  - flags[0] = zero: the WIDTH-bit result is all 0.
  - flags[1] = parity: XOR-reduction of the WIDTH-bit result.
  - flags update on the same edge as res and done, hold with res, and reset to 2'b00.
- Undefined: the flags port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, SLICE=2):
1. Basic AND: after reset, a=8'hF0, b=8'h3C, op=000, start for 1 cycle -> busy=1 for 4 cycles, then done pulses once with res=16'h0030; res still 16'h0030 three cycles later.
2. Op sweep: a=8'hF0, b=8'h3C:
   - OR -> 16'h00FC; XOR -> 16'h00CC; NAND -> 16'h00CF
   - NOR -> 16'h0003; XNOR -> 16'h0033; NOT a -> 16'h000F; PASS b -> 16'h003C
3. Isolation: start an AND with a=8'hAA, b=8'hFF. Mid-busy, change to a=8'h00, op=001 and pulse start -> single done with res=16'h00AA; no second operation starts.
4. Back-to-back: hold start=1 continuously with a=8'h0F, b=8'h0F, op=010 -> done every 5 cycles, each with res=16'h0000; busy low exactly one cycle between operations.
5. Reset mid-op: start OR of 8'h12 and 8'h34; assert rst on the 2nd busy cycle -> busy=0 and res=0 next cycle; done never pulses; a following start completes normally with res=16'h0036.
6. Flags (ALU_LOGIC_FLAGS_EN defined):
   - AND of 8'h0F and 8'hF0 -> res=16'h0000, flags=2'b01.
   - OR of 8'h07 and 8'h00 -> res=16'h0007, flags=2'b10.
